rle_encoder_stream: RTL and testbench
=====================================

// Module: rle_encoder_stream
// PURPOSE
//  Parametrised run-length encoder; successor to the fixed 8-bit compressor.
//  Consumes a valid/ready byte-or-word stream with end-of-packet marker and emits
//  (value, run count) tokens with full backpressure, count saturation and packet flush.
//  Sits between the ingest stream and the packer/serialiser in the compression datapath.
// PARAMETERS
//  DATA_W  8  width of input symbol and output value
//  CNT_W   8  width of run count; MAX_CNT = 2**CNT_W-1 (count 0 never emitted)
// PORTS
//  clk      in   1       clock; all logic on rising edge
//  rst      in   1       asynchronous, active-high reset
//  s_valid  in   1       input symbol valid
//  s_ready  out  1       encoder accepts symbol this cycle
//  s_data   in   DATA_W  input symbol
//  s_last   in   1       symbol is last of packet; forces run flush
//  m_valid  out  1       output token valid
//  m_ready  in   1       downstream accepts token
//  m_data   out  DATA_W  run value
//  m_count  out  CNT_W   run length, 1..MAX_CNT
//  m_last   out  1       token closes the packet
// BEHAVIOUR
//  - Reset (async assert, sync release): state=EMPTY, run cleared, m_valid=0,
//    m_data=0, m_count=0, m_last=0; s_ready=0 while rst high. Reset mid-run
//    discards held run and any pending token; nothing emitted.
//  - Beat accepted = s_valid & s_ready. Token transferred = m_valid & m_ready.
//  - Output is one registered slot: m_* stable while m_valid & !m_ready.
//    Slot free = !m_valid | m_ready. s_ready = slot free & state!=FLUSH.
//  - Run regs: run_data[DATA_W], run_cnt[CNT_W].
//  - States: EMPTY (no run held), RUN (run held), FLUSH (run held, must emit with last).
//  - EMPTY, beat: s_last -> emit (s_data,1,last=1), stay EMPTY;
//    else run=(s_data,1) -> RUN.
//  - RUN, beat, s_data==run_data, run_cnt<MAX_CNT: s_last -> emit
//    (run_data,run_cnt+1,1) -> EMPTY; else run_cnt++ , stay RUN.
//  - RUN, beat, s_data!=run_data OR run_cnt==MAX_CNT: emit (run_data,run_cnt,0),
//    run=(s_data,1); s_last -> FLUSH, else stay RUN.
//  - FLUSH: s_ready=0; when slot free emit (run_data,run_cnt,1) -> EMPTY.
//  - Latency: token appears on m_* the cycle after the closing beat (or FLUSH cycle).
//  - Count never wraps: saturation splits run into MAX_CNT chunk + remainder.
//  - s_valid idle cycles inside a run do not close it; only change/saturate/last do.
//  - Tokens emitted strictly in input order; no beat dropped or duplicated.
//  - Throughput: 1 beat/cycle when m_ready=1; FLUSH costs 1 extra cycle.
// TESTING
//  1. m_ready=1, 41,41,41,41,42,42,43(last) -> (41,4,0),(42,2,0),(43,1,1).
//  2. CNT_W=2: five 55, last on 5th -> (55,3,0),(55,2,1); no count 0 or wrap.
//  3. Single beat 7A with s_last from EMPTY -> (7A,1,1) next cycle, state EMPTY.
//  4. 41,41,42(last) -> (41,2,0) then FLUSH: s_ready=0 one cycle, (42,1,1).
//  5. m_ready=0 for 10 cycles over stream 41,42,41,42(last) -> s_ready drops,
//     m_* stable while stalled; after release (41,1,0),(42,1,0),(41,1,0),(42,1,1).
//  6. rst pulse after three 41 beats -> m_valid=0 immediately; then 43(last) ->
//     only (43,1,1) emitted, no stale 41 token.

Source files
------------

// File: rtl/rle_encoder_stream_if.sv
// Stream bundle for the run-length encoder.
// Carries the symbol input stream (s_*) and the (value, count) token output stream (m_*).
interface rle_encoder_stream_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  m_count;
  logic              m_last;

  // Upstream producer / downstream consumer side.
  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count, m_last
  );

  // Encoder side.
  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count, m_last
  );
endinterface

// File: rtl/rle_encoder_stream.sv
// Run-length encoder: turns a valid/ready symbol stream into (value, count, last) tokens
// through a single registered output slot, with count saturation and end-of-packet flush.
module rle_encoder_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rle_encoder_stream_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY,
    RUN,
    FLUSH
  } state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] runData_q, runData_d;
  logic [CNT_W-1:0]  runCnt_q, runCnt_d;
  logic              mValid_q, mValid_d;
  logic [DATA_W-1:0] mData_q, mData_d;
  logic [CNT_W-1:0]  mCount_q, mCount_d;
  logic              mLast_q, mLast_d;

  logic slotFree;
  logic sReady;
  logic accept;
  logic sameSym;

  assign slotFree = !mValid_q || bus.m_ready;
  assign sReady   = slotFree && (state_q != FLUSH) && !rst;
  assign accept   = bus.s_valid && sReady;
  assign sameSym  = (bus.s_data == runData_q) && (runCnt_q != MAX_CNT);

  assign bus.s_ready = sReady;
  assign bus.m_valid = mValid_q;
  assign bus.m_data  = mData_q;
  assign bus.m_count = mCount_q;
  assign bus.m_last  = mLast_q;

  // A token that is taken this cycle frees the slot unless a new one is loaded.
  always_comb begin
    state_d   = state_q;
    runData_d = runData_q;
    runCnt_d  = runCnt_q;
    mValid_d  = mValid_q && !bus.m_ready;
    mData_d   = mData_q;
    mCount_d  = mCount_q;
    mLast_d   = mLast_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          if (bus.s_last) begin
            mValid_d = 1'b1;
            mData_d  = bus.s_data;
            mCount_d = ONE;
            mLast_d  = 1'b1;
          end else begin
            runData_d = bus.s_data;
            runCnt_d  = ONE;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          if (sameSym) begin
            if (bus.s_last) begin
              mValid_d = 1'b1;
              mData_d  = runData_q;
              mCount_d = runCnt_q + ONE;
              mLast_d  = 1'b1;
              state_d  = EMPTY;
            end else begin
              runCnt_d = runCnt_q + ONE;
            end
          end else begin
            // Symbol change or saturated count closes the run; a last beat then needs FLUSH.
            mValid_d  = 1'b1;
            mData_d   = runData_q;
            mCount_d  = runCnt_q;
            mLast_d   = 1'b0;
            runData_d = bus.s_data;
            runCnt_d  = ONE;
            state_d   = bus.s_last ? FLUSH : RUN;
          end
        end
      end
      FLUSH: begin
        if (slotFree) begin
          mValid_d = 1'b1;
          mData_d  = runData_q;
          mCount_d = runCnt_q;
          mLast_d  = 1'b1;
          state_d  = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      runData_q <= '0;
      runCnt_q  <= '0;
      mValid_q  <= 1'b0;
      mData_q   <= '0;
      mCount_q  <= '0;
      mLast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      runData_q <= runData_d;
      runCnt_q  <= runCnt_d;
      mValid_q  <= mValid_d;
      mData_q   <= mData_d;
      mCount_q  <= mCount_d;
      mLast_q   <= mLast_d;
    end
  end

endmodule

// File: tb/tb_rle_encoder_stream.sv
// Scoreboard bench for rle_encoder_stream: a behavioural RLE model queues expected tokens
// as beats are accepted; monitors compare every presented token against the queue head.
module tb_rle_encoder_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       drvValid  = 1'b0;
  logic [7:0] drvData   = '0;
  logic       drvLast   = 1'b0;
  logic       drvMReady = 1'b1;
  logic       sel       = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [16:0] qA[$];
  logic [16:0] qB[$];

  logic       mdlHave = 1'b0;
  logic [7:0] mdlData = '0;
  int         mdlCnt  = 0;

  rle_encoder_stream_if #(.DATA_W(8), .CNT_W(8)) busA ();
  rle_encoder_stream_if #(.DATA_W(8), .CNT_W(2)) busB ();

  rle_encoder_stream #(.DATA_W(8), .CNT_W(8)) dutA (.clk(clk), .rst(rst), .bus(busA));
  rle_encoder_stream #(.DATA_W(8), .CNT_W(2)) dutB (.clk(clk), .rst(rst), .bus(busB));

  always #5 clk = ~clk;

  always_comb begin
    busA.s_valid = drvValid && !sel;
    busB.s_valid = drvValid && sel;
    busA.s_data  = drvData;
    busB.s_data  = drvData;
    busA.s_last  = drvLast;
    busB.s_last  = drvLast;
    busA.m_ready = drvMReady;
    busB.m_ready = drvMReady;
  end

  logic curReady;
  assign curReady = sel ? busB.s_ready : busA.s_ready;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pushTok(input logic [7:0] d, input int cnt, input logic l);
    logic [16:0] tok;
    tok = {l, 8'(cnt), d};
    if (sel) qB.push_back(tok);
    else qA.push_back(tok);
  endtask

  // Plain run-length reference: counts capped at the instance's maximum.
  task automatic modelBeat(input logic [7:0] d, input logic l);
    int maxCnt;
    maxCnt = sel ? 3 : 255;
    if (!mdlHave) begin
      mdlHave = 1'b1;
      mdlData = d;
      mdlCnt  = 1;
    end else if (d == mdlData && mdlCnt < maxCnt) begin
      mdlCnt++;
    end else begin
      pushTok(mdlData, mdlCnt, 1'b0);
      mdlData = d;
      mdlCnt  = 1;
    end
    if (l) begin
      pushTok(mdlData, mdlCnt, 1'b1);
      mdlHave = 1'b0;
    end
  endtask

  // Entered just after a rising edge; returns just after the edge that took the beat.
  task automatic applyStimulus(input logic [7:0] d, input logic l);
    bit done;
    done     = 1'b0;
    drvValid = 1'b1;
    drvData  = d;
    drvLast  = l;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (curReady) begin
        modelBeat(d, l);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    drvValid = 1'b0;
    drvLast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int i;
    drvValid = 1'b0;
    i = 0;
    while ((qA.size() != 0 || qB.size() != 0) && i < 100) begin
      @(posedge clk);
      i++;
    end
    #1;
    checkOutput(tag, 32'(qA.size() + qB.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && busA.m_valid) begin
      if (qA.size() == 0) checkOutput("A_extra_token", 32'(qA.size()), 32'd1);
      else begin
        checkOutput("A_token", 32'({busA.m_last, busA.m_count, busA.m_data}), 32'(qA[0]));
        if (busA.m_ready) void'(qA.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && busB.m_valid) begin
      if (qB.size() == 0) checkOutput("B_extra_token", 32'(qB.size()), 32'd1);
      else begin
        checkOutput("B_token", 32'({busB.m_last, 8'(busB.m_count), busB.m_data}), 32'(qB[0]));
        if (busB.m_ready) void'(qB.pop_front());
      end
    end
  end

  initial begin
    #2;
    checkOutput("rst_m_valid", 32'(busA.m_valid), 32'd0);
    checkOutput("rst_m_data",  32'(busA.m_data),  32'd0);
    checkOutput("rst_m_count", 32'(busA.m_count), 32'd0);
    checkOutput("rst_m_last",  32'(busA.m_last),  32'd0);
    checkOutput("rst_s_ready", 32'(busA.s_ready), 32'd0);
    #20 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic runs, continuous flow.
    $display("[TB] test 1: runs with m_ready=1");
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h42, 1'b0);
    applyStimulus(8'h42, 1'b0);
    applyStimulus(8'h43, 1'b1);
    drain("t1_drain");

    // Single-beat packet appears on the very next cycle.
    $display("[TB] test 3: single last beat");
    applyStimulus(8'h7A, 1'b1);
    drvValid = 1'b0;
    checkOutput("t3_m_valid", 32'(busA.m_valid), 32'd1);
    checkOutput("t3_m_token", 32'({busA.m_last, busA.m_count, busA.m_data}), 32'h1017A);
    @(negedge clk);
    checkOutput("t3_s_ready", 32'(busA.s_ready), 32'd1);
    drain("t3_drain");

    // Symbol change on the last beat forces a flush cycle.
    $display("[TB] test 4: flush");
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h42, 1'b1);
    drvValid = 1'b0;
    checkOutput("t4_flush_s_ready", 32'(busA.s_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t4_after_s_ready", 32'(busA.s_ready), 32'd1);
    drain("t4_drain");

    // Downstream stall across a changing stream.
    $display("[TB] test 5: backpressure");
    fork
      begin
        drvMReady = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_s_ready_low", 32'(curReady), 32'd0);
        drvMReady = 1'b1;
      end
      begin
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h42, 1'b0);
        applyStimulus(8'h41, 1'b0);
        applyStimulus(8'h42, 1'b1);
      end
    join
    drain("t5_drain");

    // Idle gaps inside a run keep it open.
    $display("[TB] gaps inside a run");
    applyStimulus(8'h10, 1'b0);
    idle(3);
    applyStimulus(8'h10, 1'b0);
    idle(2);
    applyStimulus(8'h10, 1'b1);
    drain("gap_drain");

    // Reset mid-run discards the held run.
    $display("[TB] test 6: reset mid-run");
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h41, 1'b0);
    applyStimulus(8'h41, 1'b0);
    drvValid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t6_m_valid", 32'(busA.m_valid), 32'd0);
    checkOutput("t6_s_ready", 32'(busA.s_ready), 32'd0);
    qA.delete();
    mdlHave = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(8'h43, 1'b1);
    drain("t6_drain");

    // Saturation on the narrow-count instance.
    $display("[TB] test 2: count saturation, CNT_W=2");
    sel = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(8'h55, (i == 4));
    drain("t2_drain");
    for (int i = 0; i < 8; i++) applyStimulus(8'h66, (i == 7));
    drain("t2b_drain");
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=1 exp=0");
    $fatal(1, "[TB] timeout");
  end

endmodule
